rst_sequencer: RTL

- Parametrised board-level reset sequencer sitting between the clock wizard and the functional top.
- Waits for the clock wizard `locked` signal, debounces the raw reset button, and holds all downstream resets for a programmable time.
- Releases N_CH active-high domain resets in staggered order, then raises `ready`.
- Re-enters sequencing on button press or loss of lock, and counts button-initiated resets.

---
 rtl/rst_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rst_sequencer.sv
// Board-level reset sequencer: waits for clock lock, debounces the reset button,
// holds all domain resets, then releases them in staggered order and raises ready.
module rst_sequencer #(
  parameter int unsigned N_CH            = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 65000,
  parameter int unsigned HOLD_CYCLES     = 256,
  parameter int unsigned STAGGER_CYCLES  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            locked,
  input  logic            btn,
  output logic [N_CH-1:0] rst_out,
  output logic            ready,
  output logic [7:0]      btn_resets
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CH_W    = $clog2(N_CH + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    RUN
  } state_t;

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic                   w_lock_s;
  logic                   w_btn_s;

  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_btn_db;
  logic                   w_db_diff;
  logic                   w_db_flip;
  logic                   w_press;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CH_W-1:0]        r_ch;
  logic [CH_W-1:0]        w_ch_nxt;
  logic [N_CH-1:0]        r_rst_out;
  logic [N_CH-1:0]        w_rst_nxt;
  logic                   r_ready;
  logic                   w_ready_nxt;
  logic [7:0]             r_btn_resets;
  logic [7:0]             w_resets_nxt;
  logic                   w_abort_lock;
  logic                   w_abort_btn;

  // Synchronisers for the two asynchronous inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_sync <= '0;
      r_btn_sync  <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked};
      r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], btn};
    end
  end

  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
  assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];

  // A press is taken on the edge btn_db rises, so the FSM reacts on that same edge
  assign w_db_diff = (w_btn_s != r_btn_db);
  assign w_db_flip = w_db_diff && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign w_press   = w_db_flip && w_btn_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_btn_db <= 1'b0;
    end else if (!w_db_diff) begin
      r_db_cnt <= '0;
    end else if (w_db_flip) begin
      r_btn_db <= w_btn_s;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= WAIT_LOCK;
      r_cnt        <= '0;
      r_ch         <= '0;
      r_rst_out    <= '1;
      r_ready      <= 1'b0;
      r_btn_resets <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ch         <= w_ch_nxt;
      r_rst_out    <= w_rst_nxt;
      r_ready      <= w_ready_nxt;
      r_btn_resets <= w_resets_nxt;
    end
  end

  assign w_abort_lock = (r_state != WAIT_LOCK) && !w_lock_s;
  assign w_abort_btn  = ((r_state == RELEASE) || (r_state == RUN)) && w_press;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ch_nxt     = r_ch;
    w_rst_nxt    = r_rst_out;
    w_ready_nxt  = r_ready;
    w_resets_nxt = r_btn_resets;

    unique case (r_state)
      WAIT_LOCK: begin
        w_rst_nxt   = '1;
        w_ready_nxt = 1'b0;
        if (w_lock_s) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_ch_nxt    = '0;
        end
      end
      HOLD: begin
        w_rst_nxt   = '1;
        w_ready_nxt = 1'b0;
        if (r_btn_db) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          w_state_nxt  = RELEASE;
          w_rst_nxt[0] = 1'b0;
          w_ch_nxt     = CH_W'(1);
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (r_cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
          w_cnt_nxt = '0;
          if (r_ch == CH_W'(N_CH)) begin
            w_state_nxt = RUN;
            w_ready_nxt = 1'b1;
          end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
              if (CH_W'(i) == r_ch) w_rst_nxt[i] = 1'b0;
            end
            w_ch_nxt = r_ch + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        w_rst_nxt   = '0;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = WAIT_LOCK;
        w_rst_nxt   = '1;
        w_ready_nxt = 1'b0;
      end
    endcase

    // Lock loss outranks a press; a press lost to lock loss is not counted
    if (w_abort_lock) begin
      w_state_nxt = WAIT_LOCK;
      w_rst_nxt   = '1;
      w_ready_nxt = 1'b0;
      w_cnt_nxt   = '0;
      w_ch_nxt    = '0;
    end else if (w_abort_btn) begin
      w_state_nxt = HOLD;
      w_rst_nxt   = '1;
      w_ready_nxt = 1'b0;
      w_cnt_nxt   = '0;
      w_ch_nxt    = '0;
      if (r_btn_resets != 8'hFF) w_resets_nxt = r_btn_resets + 1'b1;
    end
  end

  assign rst_out    = r_rst_out;
  assign ready      = r_ready;
  assign btn_resets = r_btn_resets;

endmodule
